// File: rtl/mul_pkg.sv
// Shared constants and the Booth selector type for the pipelined 16x16 signed multiplier.
package mul_pkg;

  localparam int OPW = 16;
  localparam int PW  = 32;
  localparam int NPP = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic zero;
    logic one;
    logic double;
    logic reverse;
  } booth_sel_t;

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier group -> magnitude select and sign.
module booth_enc
  import mul_pkg::*;
(
  input  logic [2:0] grp,
  output booth_sel_t sel
);

  always_comb begin
    sel = '0;
    unique case (grp)
      3'b000, 3'b111: sel.zero   = 1'b1;
      3'b001, 3'b010: sel.one    = 1'b1;
      3'b011:         sel.double = 1'b1;
      3'b100:         begin sel.double = 1'b1; sel.reverse = 1'b1; end
      3'b101, 3'b110: begin sel.one    = 1'b1; sel.reverse = 1'b1; end
      default:        sel.zero   = 1'b1;
    endcase
  end

endmodule

// File: rtl/compressor32.sv
// 3:2 carry-save adder; cout carries weight 2 and is shifted by the caller.
module compressor32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  assign sum  = x0 ^ x1 ^ x2;
  assign cout = (x0 & x1) | (x0 & x2) | (x1 & x2);

endmodule

// File: rtl/compressor42.sv
// 4:2 compressor built from two 3:2 levels: x0+x1+x2+x3 == 2*cout + sum (mod 2^WIDTH).
module compressor42 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;

  assign s1 = x0 ^ x1 ^ x2;
  // Internal carry moves up one bit here; its top bit falls off the modulus.
  assign c1 = {(x0[WIDTH-2:0] & x1[WIDTH-2:0]) |
               (x0[WIDTH-2:0] & x2[WIDTH-2:0]) |
               (x1[WIDTH-2:0] & x2[WIDTH-2:0]), 1'b0};

  assign sum  = s1 ^ c1 ^ x3;
  assign cout = (s1 & c1) | (s1 & x3) | (c1 & x3);

endmodule

// File: rtl/booth_mul16_pipe.sv
// Four-stage pipelined signed 16x16 -> 32 multiplier: Booth recoding, carry-save tree, final CPA.
module booth_mul16_pipe
  import mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [OPW-1:0] a,
  input  logic signed [OPW-1:0] b,
  output logic                  out_valid,
  output logic signed [PW-1:0]  p
);

  // Negative groups are inverted before the shift so only the +1 at bit 2*idx is owed.
  function automatic logic signed [PW-1:0] pp_gen(input booth_sel_t s,
                                                  input logic signed [OPW-1:0] x,
                                                  input int idx);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] m;
    xe = {{(PW-OPW){x[OPW-1]}}, x};
    m  = s.one ? xe : (s.double ? (xe <<< 1) : '0);
    if (s.reverse) m = ~m;
    return m << (2 * idx);
  endfunction

  logic [OPW:0]         b_ext;
  booth_sel_t           sel [NPP];
  logic signed [PW-1:0] pp_p0 [NPP];
  logic [PW-1:0]        neg_p0;

  assign b_ext = {b, 1'b0};

  for (genvar gi = 0; gi < NPP; gi++) begin : g_enc
    booth_enc u_enc (
      .grp (b_ext[2*gi+2:2*gi]),
      .sel (sel[gi])
    );
  end

  always_comb begin
    neg_p0 = '0;
    for (int i = 0; i < NPP; i++) begin
      pp_p0[i] = pp_gen(sel[i], a, i);
      if (sel[i].reverse) neg_p0[2*i] = 1'b1;
    end
  end

  // ---- stage 1: partial products and correction vector ----
  logic                 vld_p1;
  logic signed [PW-1:0] pp_p1 [NPP];
  logic [PW-1:0]        neg_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pp_p1  <= '{default: '0};
      neg_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        pp_p1  <= pp_p0;
        neg_p1 <= neg_p0;
      end
    end
  end

  logic [PW-1:0] s_lo_p1, c_lo_p1, s_hi_p1, c_hi_p1;

  compressor42 #(.WIDTH(PW)) u_c42_lo (
    .x0 (pp_p1[0]), .x1 (pp_p1[1]), .x2 (pp_p1[2]), .x3 (pp_p1[3]),
    .sum (s_lo_p1), .cout (c_lo_p1)
  );

  compressor42 #(.WIDTH(PW)) u_c42_hi (
    .x0 (pp_p1[4]), .x1 (pp_p1[5]), .x2 (pp_p1[6]), .x3 (pp_p1[7]),
    .sum (s_hi_p1), .cout (c_hi_p1)
  );

  // ---- stage 2: four carry-save vectors plus the correction vector ----
  logic                 vld_p2;
  logic signed [PW-1:0] v_p2 [4];
  logic [PW-1:0]        neg_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      v_p2   <= '{default: '0};
      neg_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        v_p2[0] <= s_lo_p1;
        v_p2[1] <= c_lo_p1 << 1;
        v_p2[2] <= s_hi_p1;
        v_p2[3] <= c_hi_p1 << 1;
        neg_p2  <= neg_p1;
      end
    end
  end

  logic [PW-1:0] s_a_p2, c_a_p2, s_b_p2, c_b_p2;

  compressor42 #(.WIDTH(PW)) u_c42_top (
    .x0 (v_p2[0]), .x1 (v_p2[1]), .x2 (v_p2[2]), .x3 (v_p2[3]),
    .sum (s_a_p2), .cout (c_a_p2)
  );

  compressor32 #(.WIDTH(PW)) u_c32 (
    .x0 (s_a_p2), .x1 (c_a_p2 << 1), .x2 (neg_p2),
    .sum (s_b_p2), .cout (c_b_p2)
  );

  // ---- stage 3: final sum/carry pair ----
  logic                 vld_p3;
  logic signed [PW-1:0] sum_p3;
  logic signed [PW-1:0] carry_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3   <= 1'b0;
      sum_p3   <= '0;
      carry_p3 <= '0;
    end else begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        sum_p3   <= s_b_p2;
        carry_p3 <= c_b_p2 << 1;
      end
    end
  end

  // ---- stage 4: carry-propagate add into the product register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      out_valid <= vld_p3;
      if (vld_p3) p <= sum_p3 + carry_p3;
    end
  end

endmodule

// File: tb/tb_booth_mul16_pipe.sv
// Scoreboard bench for booth_mul16_pipe plus exhaustive checks of compressor42 and booth_enc.
module tb_booth_mul16_pipe;
  import mul_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic               out_valid;
  logic signed [31:0] p;

  logic [3:0] cx0 = '0, cx1 = '0, cx2 = '0, cx3 = '0;
  logic [3:0] cs, cc;
  logic [2:0] grp = '0;
  booth_sel_t bsel;

  always #5 clk = ~clk;

  booth_mul16_pipe dut (
    .clk (clk), .rst (rst), .in_valid (in_valid),
    .a (a), .b (b), .out_valid (out_valid), .p (p)
  );

  compressor42 #(.WIDTH(4)) u_c42 (
    .x0 (cx0), .x1 (cx1), .x2 (cx2), .x3 (cx3), .sum (cs), .cout (cc)
  );

  booth_enc u_be (.grp (grp), .sel (bsel));

  typedef struct {
    logic signed [15:0] ta;
    logic signed [15:0] tb;
    logic [31:0]        exp;
    int                 due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented product must match the oldest outstanding request on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out p=%h cyc=%0d", p, cyc);
        end else begin
          e = sb.pop_front();
          if (p !== e.exp || cyc != e.due) begin
            n_fail++;
            $display("FAIL product a=%0d b=%0d p=%h exp=%h cyc=%0d due=%0d",
                     e.ta, e.tb, p, e.exp, cyc, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_tests++;
        n_fail++;
        e = sb.pop_front();
        $display("FAIL late_out a=%0d b=%0d exp=%h cyc=%0d due=%0d", e.ta, e.tb, e.exp, cyc, e.due);
      end
    end
  end

  task automatic issue(input logic signed [15:0] ta, input logic signed [15:0] tb_,
                       input logic [31:0] e);
    @(negedge clk);
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    sb.push_back('{ta, tb_, e, cyc + 4});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  logic [3:0] be_tab [8] = '{4'b1000, 4'b0100, 4'b0100, 4'b0010,
                             4'b0011, 4'b0101, 4'b0101, 4'b1000};

  initial begin
    logic signed [15:0] ra, rb;
    logic signed [31:0] re;
    int lhs, rhs, budget;

    #1;
    check("reset_p", p, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single transaction, latency and single-cycle valid
    issue(16'sd3, 16'sd5, 32'h0000000F);
    idle(8);

    // Back-to-back corners
    issue(-16'sd1, -16'sd1, 32'h00000001);
    issue(-16'sd32768, -16'sd32768, 32'h40000000);
    issue(16'sd32767, -16'sd32768, 32'hC0008000);
    issue(16'sd0, 16'sd1234, 32'h00000000);
    issue(16'sd1, -16'sd1, 32'hFFFFFFFF);
    issue(16'sd12345, -16'sd2, 32'hFFFF9F8E);
    issue(16'sd255, 16'sd255, 32'h0000FE01);
    issue(-16'sd32768, 16'sd1, 32'hFFFF8000);
    issue(-16'sd32768, 16'sd32767, 32'hC0008000);
    idle(8);

    // Mid-flight reset flushes the pipeline and clears p
    issue(-16'sd3, 16'sd7, 32'hFFFFFFEB);
    idle(6);
    check("hold_p", p, 32'hFFFFFFEB);
    issue(16'sd100, 16'sd100, 32'h00002710);
    idle(1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_p", p, 32'h0);
    check("rst_async_valid", {31'b0, out_valid}, 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    check("post_flush_p", p, 32'h0);

    // Random pairs with random gaps
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(3) != 0) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        re = ra * rb;
        a = ra;
        b = rb;
        in_valid = 1'b1;
        sb.push_back('{ra, rb, re, cyc + 4});
      end else begin
        in_valid = 1'b0;
      end
    end
    idle(1);
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", 32'(sb.size()), 32'h0);

    // compressor42 exhaustive at WIDTH=4
    for (int v = 0; v < 65536; v++) begin
      {cx3, cx2, cx1, cx0} = v[15:0];
      #1;
      lhs = (2 * int'(cc) + int'(cs)) % 16;
      rhs = (int'(cx0) + int'(cx1) + int'(cx2) + int'(cx3)) % 16;
      n_tests++;
      if (lhs != rhs) begin
        n_fail++;
        $display("FAIL c42 in=%h got=%0d want=%0d", v[15:0], lhs, rhs);
      end
    end

    // booth_enc truth table
    for (int g = 0; g < 8; g++) begin
      grp = g[2:0];
      #1;
      check("booth_enc", {28'b0, bsel}, {28'b0, be_tab[g]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
